// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding, byte width and a clog2 helper.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } arbState_e;

    // Ceiling log2 with a floor of 1 so a 1-bit index always exists.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin winner select for the UART transmit arbiter.
// Scans a doubled valid vector from the pointer to get wrap-around priority.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [ID_W-1:0]    ptr,
    output logic               anyValid,
    output logic [ID_W-1:0]    winner
);

    logic [2*NUM_REQ-1:0] dblValid;
    logic [2*NUM_REQ-1:0] masked;

    // Mask off every doubled position below the pointer.
    always_comb begin
        dblValid = {reqValid, reqValid};
        masked   = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dblValid[i] && (i >= int'(ptr));
        end
    end

    // Lowest surviving position wins; fold it back into requester range.
    always_comb begin
        winner = '0;
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                winner = ID_W'(i % NUM_REQ);
            end
        end
    end

    assign anyValid = |reqValid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of one UART transmitter.
// A grant holds until a last byte is sent or the owner idles too long.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int HOLD_TIMEOUT = 1024,
    localparam int ID_W         = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id,
    output logic                      err_timeout
);

    localparam logic [15:0]     HOLD_LAST = 16'(HOLD_TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    arbState_e         state;
    arbState_e         stateNxt;
    logic [ID_W-1:0]   rrPtr;
    logic [ID_W-1:0]   nextPtr;
    logic [ID_W-1:0]   winner;
    logic              anyValid;
    logic              lastFlag;
    logic [15:0]       holdCnt;

    logic              grantValid;
    logic              grantLast;
    logic [BYTE_W-1:0] grantData;

    logic              doLaunch;
    logic              doAccept;
    logic              doRelease;
    logic              doTimeout;
    logic              holdClr;
    logic              holdInc;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) picker (
        .reqValid (req_valid),
        .ptr      (rrPtr),
        .anyValid (anyValid),
        .winner   (winner)
    );

    assign grantValid = req_valid[grant_id];
    assign grantLast  = req_last[grant_id];
    assign grantData  = req_data[BYTE_W*grant_id +: BYTE_W];

    assign nextPtr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // Accept strobe goes only to the lock owner, only while loading.
    always_comb begin
        req_ready = '0;
        if (state == LOAD) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state and control decode.
    always_comb begin
        stateNxt  = state;
        doLaunch  = 1'b0;
        doAccept  = 1'b0;
        doRelease = 1'b0;
        doTimeout = 1'b0;
        holdClr   = 1'b0;
        holdInc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_busy && anyValid) begin
                    doLaunch = 1'b1;
                    stateNxt = LOAD;
                end
            end
            LOAD: begin
                if (grantValid) begin
                    doAccept = 1'b1;
                    stateNxt = WAIT_BUSY;
                end else begin
                    holdClr  = 1'b1;
                    stateNxt = HOLD;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    stateNxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lastFlag) begin
                        doRelease = 1'b1;
                        stateNxt  = IDLE;
                    end else begin
                        holdClr  = 1'b1;
                        stateNxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (grantValid) begin
                    holdClr  = 1'b1;
                    stateNxt = LOAD;
                end else if (holdCnt == HOLD_LAST) begin
                    doRelease = 1'b1;
                    doTimeout = 1'b1;
                    holdClr   = 1'b1;
                    stateNxt  = IDLE;
                end else begin
                    holdInc = 1'b1;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Grant lock, owner id and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_active <= 1'b0;
            grant_id     <= '0;
            rrPtr        <= '0;
        end else if (doLaunch) begin
            grant_active <= 1'b1;
            grant_id     <= winner;
        end else if (doRelease) begin
            grant_active <= 1'b0;
            rrPtr        <= nextPtr;
        end
    end

    // Byte capture and single-cycle start toward the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            lastFlag <= 1'b0;
        end else begin
            tx_start <= doAccept;
            if (doAccept) begin
                tx_data  <= grantData;
                lastFlag <= grantLast;
            end
        end
    end

    // Idle counter while the owner has nothing to send mid-packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdCnt <= '0;
        end else if (holdClr) begin
            holdCnt <= '0;
        end else if (holdInc) begin
            holdCnt <= holdCnt + 16'd1;
        end
    end

    // One-cycle flag when a lock is dropped by the idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= doTimeout;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for the UART transmit arbiter.
// Queue-fed requesters and a busy model stand in for the transmitter.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int HOLD_TO = 8;
    localparam int FRAME   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        err_timeout;

    logic modelBusy = 1'b0;
    logic forceBusy = 1'b0;
    int   busyCnt = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   startCount = 0;

    logic [8:0] srcQ [NUM_REQ][$];
    logic [9:0] expQ [$];

    assign tx_busy = modelBusy | forceBusy;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .HOLD_TIMEOUT (HOLD_TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .err_timeout  (err_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor, transmitter busy model and queue-driven requesters.
    initial begin
        logic [3:0] readySeen;
        logic       startSeen;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            readySeen = req_ready;
            startSeen = tx_start;
            if (rst_n) begin
                nChecks++;
                if (tx_start && tx_busy) begin
                    nFails++;
                    $display("FAIL start_while_busy: tx_start=%b tx_busy=%b, required not both",
                             tx_start, tx_busy);
                end
                nChecks++;
                if ($countones(req_ready) > 1) begin
                    nFails++;
                    $display("FAIL ready_onehot: req_ready=%b, required at most one bit",
                             req_ready);
                end
                if (tx_start) begin
                    startCount++;
                    nChecks++;
                    if (expQ.size() == 0) begin
                        nFails++;
                        $display("FAIL unexpected_start: id=%0d data=%h, none expected",
                                 grant_id, tx_data);
                    end else begin
                        e = expQ.pop_front();
                        if ({grant_id, tx_data} !== e) begin
                            nFails++;
                            $display("FAIL sb_byte: got id=%0d data=%h, expected id=%0d data=%h",
                                     grant_id, tx_data, e[9:8], e[7:0]);
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (startSeen && busyCnt == 0) begin
                busyCnt = FRAME;
            end else if (busyCnt > 0) begin
                busyCnt--;
            end
            modelBusy = (busyCnt != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (readySeen[i] && srcQ[i].size() > 0) begin
                    void'(srcQ[i].pop_front());
                end
                if (srcQ[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = srcQ[i][0][7:0];
                    req_last[i]         = srcQ[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(output bit timedOut);
        bool_loop: begin
            timedOut = 1'b1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (expQ.size() == 0 && !tx_busy && !grant_active &&
                    srcQ[0].size() == 0 && srcQ[1].size() == 0 &&
                    srcQ[2].size() == 0 && srcQ[3].size() == 0) begin
                    timedOut = 1'b0;
                    disable bool_loop;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nChecks++;
        if ({req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout} !== 17'd0) begin
            nFails++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout});
        end
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout} !== 17'd0 ||
            dut.rrPtr !== 2'd0) begin
            nFails++;
            $display("FAIL reset_idle: outs=%h ptr=%0d, expected 0 and 0",
                     {req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout},
                     dut.rrPtr);
        end
    endtask

    task automatic test_single();
        bit found;
        bit to;
        srcQ[2].push_back({1'b1, 8'h41});
        expQ.push_back({2'd2, 8'h41});
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            @(negedge clk);
            if (req_valid[2]) found = 1'b1;
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL single_valid: req_valid=%b, expected bit 2 set", req_valid);
        end
        @(negedge clk);
        nChecks++;
        if (req_ready !== 4'b0100) begin
            nFails++;
            $display("FAIL single_ready: got %b, expected 0100", req_ready);
        end
        @(negedge clk);
        nChecks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            nFails++;
            $display("FAIL single_start: start=%b data=%h, expected 1 and 41",
                     tx_start, tx_data);
        end
        @(negedge clk);
        nChecks++;
        if (tx_start !== 1'b0) begin
            nFails++;
            $display("FAIL single_start_pulse: got %b, expected 0", tx_start);
        end
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (!tx_busy) found = 1'b1;
        end
        nChecks++;
        if (!found || grant_active !== 1'b1) begin
            nFails++;
            $display("FAIL single_busy_fall: seen=%b active=%b, expected 1 and 1",
                     found, grant_active);
        end
        @(negedge clk);
        nChecks++;
        if (grant_active !== 1'b0 || dut.rrPtr !== 2'd3) begin
            nFails++;
            $display("FAIL single_release: active=%b ptr=%0d, expected 0 and 3",
                     grant_active, dut.rrPtr);
        end
        wait_idle(to);
        nChecks++;
        if (to) begin
            nFails++;
            $display("FAIL single_idle: timed out, expected idle");
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int base;
        do_reset();
        base = startCount;
        srcQ[0].push_back({1'b1, 8'hA0});
        srcQ[0].push_back({1'b1, 8'hA4});
        srcQ[1].push_back({1'b1, 8'hB1});
        srcQ[2].push_back({1'b1, 8'hC2});
        srcQ[3].push_back({1'b1, 8'hD3});
        expQ.push_back({2'd0, 8'hA0});
        expQ.push_back({2'd1, 8'hB1});
        expQ.push_back({2'd2, 8'hC2});
        expQ.push_back({2'd3, 8'hD3});
        expQ.push_back({2'd0, 8'hA4});
        wait_idle(to);
        nChecks++;
        if (to || startCount - base != 5) begin
            nFails++;
            $display("FAIL rr_starts: timeout=%b starts=%0d, expected 0 and 5",
                     to, startCount - base);
        end
        nChecks++;
        if (dut.rrPtr !== 2'd1) begin
            nFails++;
            $display("FAIL rr_ptr: got %0d, expected 1", dut.rrPtr);
        end
    endtask

    task automatic test_packet_lock();
        bit to;
        bit broken;
        srcQ[1].push_back({1'b0, 8'h10});
        srcQ[1].push_back({1'b0, 8'h11});
        srcQ[1].push_back({1'b1, 8'h12});
        srcQ[0].push_back({1'b1, 8'h20});
        srcQ[3].push_back({1'b1, 8'h30});
        expQ.push_back({2'd1, 8'h10});
        expQ.push_back({2'd1, 8'h11});
        expQ.push_back({2'd1, 8'h12});
        expQ.push_back({2'd3, 8'h30});
        expQ.push_back({2'd0, 8'h20});
        broken = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (expQ.size() <= 2) break;
            if (expQ.size() < 5 && (grant_active !== 1'b1 || grant_id !== 2'd1)) begin
                broken = 1'b1;
            end
        end
        nChecks++;
        if (broken || expQ.size() > 2) begin
            nFails++;
            $display("FAIL lock_held: broken=%b left=%0d, expected 0 and <=2",
                     broken, expQ.size());
        end
        wait_idle(to);
        nChecks++;
        if (to) begin
            nFails++;
            $display("FAIL lock_idle: timed out, expected idle");
        end
    endtask

    task automatic test_hold_timeout();
        bit to;
        bit found;
        srcQ[0].push_back({1'b0, 8'h55});
        expQ.push_back({2'd0, 8'h55});
        expQ.push_back({2'd1, 8'h66});
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (tx_start) found = 1'b1;
        end
        srcQ[1].push_back({1'b1, 8'h66});
        for (int k = 0; k < 5 && !tx_busy; k++) @(negedge clk);
        for (int k = 0; k < 40 && tx_busy; k++) @(negedge clk);
        nChecks++;
        if (!found || tx_busy) begin
            nFails++;
            $display("FAIL hold_frame: start=%b busy=%b, expected 1 and 0", found, tx_busy);
        end
        repeat (8) @(negedge clk);
        nChecks++;
        if (err_timeout !== 1'b0 || grant_active !== 1'b1) begin
            nFails++;
            $display("FAIL hold_early: err=%b active=%b, expected 0 and 1",
                     err_timeout, grant_active);
        end
        @(negedge clk);
        nChecks++;
        if (err_timeout !== 1'b1 || grant_active !== 1'b0) begin
            nFails++;
            $display("FAIL hold_timeout: err=%b active=%b, expected 1 and 0",
                     err_timeout, grant_active);
        end
        @(negedge clk);
        nChecks++;
        if (err_timeout !== 1'b0 || req_ready !== 4'b0010) begin
            nFails++;
            $display("FAIL hold_next: err=%b ready=%b, expected 0 and 0010",
                     err_timeout, req_ready);
        end
        wait_idle(to);
        nChecks++;
        if (to) begin
            nFails++;
            $display("FAIL hold_idle: timed out, expected idle");
        end
    endtask

    task automatic test_busy_guard();
        bit to;
        bit bad;
        forceBusy = 1'b1;
        srcQ[0].push_back({1'b1, 8'h77});
        expQ.push_back({2'd0, 8'h77});
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || req_ready !== 4'b0000 || grant_active !== 1'b0) begin
                bad = 1'b1;
            end
        end
        nChecks++;
        if (bad) begin
            nFails++;
            $display("FAIL guard_blocked: launch seen under busy, expected none");
        end
        forceBusy = 1'b0;
        @(negedge clk);
        nChecks++;
        if (req_ready !== 4'b0001) begin
            nFails++;
            $display("FAIL guard_ready: got %b, expected 0001", req_ready);
        end
        @(negedge clk);
        nChecks++;
        if (tx_start !== 1'b1) begin
            nFails++;
            $display("FAIL guard_start: got %b, expected 1", tx_start);
        end
        wait_idle(to);
        nChecks++;
        if (to) begin
            nFails++;
            $display("FAIL guard_idle: timed out, expected idle");
        end
    endtask

    task automatic test_reset_wait_done();
        bit to;
        bit bad;
        srcQ[2].push_back({1'b0, 8'h88});
        srcQ[2].push_back({1'b1, 8'h89});
        expQ.push_back({2'd2, 8'h88});
        expQ.push_back({2'd2, 8'h89});
        for (int k = 0; k < 20 && !tx_start; k++) @(negedge clk);
        for (int k = 0; k < 5 && !tx_busy; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout} !== 17'd0 ||
            dut.rrPtr !== 2'd0) begin
            nFails++;
            $display("FAIL rst_async: outs=%h ptr=%0d, expected 0 and 0",
                     {req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout},
                     dut.rrPtr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nChecks++;
        if (tx_busy !== 1'b1) begin
            nFails++;
            $display("FAIL rst_busy: got %b, expected 1 (frame still in flight)", tx_busy);
        end
        bad = 1'b0;
        for (int k = 0; k < 40 && tx_busy; k++) begin
            @(negedge clk);
            if (tx_busy && (tx_start !== 1'b0 || req_ready !== 4'b0000)) bad = 1'b1;
        end
        nChecks++;
        if (bad || tx_busy) begin
            nFails++;
            $display("FAIL rst_guard: bad=%b busy=%b, expected 0 and 0", bad, tx_busy);
        end
        @(negedge clk);
        nChecks++;
        if (req_ready !== 4'b0100) begin
            nFails++;
            $display("FAIL rst_rearb: got %b, expected 0100", req_ready);
        end
        wait_idle(to);
        nChecks++;
        if (to) begin
            nFails++;
            $display("FAIL rst_idle: timed out, expected idle");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_hold_timeout();
        test_busy_guard();
        test_reset_wait_done();
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL sb_drain: %0d bytes left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
